port_bus_arbiter: RTL and testbench

Shares the single I/O port bus (port_addr/port_out/port_bit/port_clk/port_read/port_in) between two requesters: requester 0 is the CPU core, requester 1 is the debug/loader channel. It sequences every access as setup → strobe → hold, so the port controller's falling-edge detector sees a clean pulse over a stable address. It captures port_in after the controller has updated its output register, and returns the data with a one-cycle ack. It sits between the requesters and port_controller, and is the only driver of the port bus.

---
 rtl/port_bus_pkg.sv | 20 ++
 rtl/port_arb_pick.sv | 19 +
 rtl/port_bus_arbiter.sv | 142 ++++++++++++++
 tb/tb_port_bus_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/port_bus_pkg.sv
// Shared types and constants for the port bus arbiter and its helpers.
package port_bus_pkg;

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, ACK} state_t;

  localparam logic [15:0] KBD_DATA_PORT = 16'h0060;
  localparam logic [15:0] KBD_STAT_PORT = 16'h0064;

  typedef struct packed {
    logic        we;
    logic        bit_w;
    logic [15:0] addr;
    logic [15:0] wdata;
  } cmd_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/port_arb_pick.sv
// Two-requester winner select; ptr names the requester preferred on a tie.
module port_arb_pick
  import port_bus_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic ptr,
  output logic gnt_vld,
  output logic gnt_sel
);

  always_comb begin
    gnt_vld = req0 | req1;
    gnt_sel = 1'b0;
    if (req0 && req1) gnt_sel = ptr;
    else if (req1)    gnt_sel = 1'b1;
  end

endmodule

// File: rtl/port_bus_arbiter.sv
// Two-master port bus arbiter sequencing setup/strobe/hold/ack accesses.
// Define PORT_ARB_RR_EN for round-robin tie breaking (default: requester 0 wins).
module port_bus_arbiter
  import port_bus_pkg::*;
#(
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 2
) (
  input  logic        clock50,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  input  logic        bit0,
  input  logic        bit1,
  output logic        ack0,
  output logic        ack1,
  output logic [15:0] rdata0,
  output logic [15:0] rdata1,
  output logic [15:0] port_addr,
  output logic [15:0] port_out,
  output logic        port_bit,
  output logic        port_clk,
  output logic        port_read,
  input  logic [15:0] port_in
);

  localparam int CNT_W = $clog2(max2(STROBE_CYC, HOLD_CYC) + 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             win;
  logic             cur_we;
  logic             ptr;
  logic             gnt_vld;
  logic             gnt_sel;
  cmd_t             cmd_sel;

`ifdef PORT_ARB_RR_EN
  logic ptr_q;
  assign ptr = ptr_q;
`else
  assign ptr = 1'b0;
`endif

  port_arb_pick u_pick (
    .req0    (req0),
    .req1    (req1),
    .ptr     (ptr),
    .gnt_vld (gnt_vld),
    .gnt_sel (gnt_sel)
  );

  always_comb begin
    cmd_sel = gnt_sel ? cmd_t'{we: we1, bit_w: bit1, addr: addr1, wdata: wdata1}
                      : cmd_t'{we: we0, bit_w: bit0, addr: addr0, wdata: wdata0};
  end

  // Strobes and ack are registered so the bus sees glitch-free edges.
  always_ff @(posedge clock50 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      win       <= 1'b0;
      cur_we    <= 1'b0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      port_addr <= '0;
      port_out  <= '0;
      port_bit  <= 1'b0;
      port_clk  <= 1'b0;
      port_read <= 1'b0;
`ifdef PORT_ARB_RR_EN
      ptr_q     <= 1'b0;
`endif
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_vld) begin
            win       <= gnt_sel;
            cur_we    <= cmd_sel.we;
            port_addr <= cmd_sel.addr;
            port_out  <= cmd_sel.wdata;
            port_bit  <= cmd_sel.bit_w;
            cnt       <= '0;
            state     <= SETUP;
          end
        end
        SETUP: begin
          port_read <= ~cur_we;
          port_clk  <= cur_we;
          cnt       <= STROBE_LD;
          state     <= STROBE;
        end
        STROBE: begin
          if (cnt == '0) begin
            port_read <= 1'b0;
            port_clk  <= 1'b0;
            cnt       <= HOLD_LD;
            state     <= HOLD;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            // The controller has settled its output register by the last hold edge.
            if (!cur_we) begin
              if (win) rdata1 <= port_in;
              else     rdata0 <= port_in;
            end
            ack0  <= ~win;
            ack1  <= win;
            cnt   <= '0;
            state <= ACK;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ACK: begin
`ifdef PORT_ARB_RR_EN
          ptr_q <= ~win;
`endif
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_port_bus_arbiter.sv
// Scoreboard bench for port_bus_arbiter: directed cases plus random two-master traffic.
`timescale 1ns/1ps
module tb_port_bus_arbiter;
  import port_bus_pkg::*;

  localparam int STROBE_CYC = 2;
  localparam int HOLD_CYC   = 2;

  logic        clock50 = 1'b0;
  logic        rst_n   = 1'b0;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0, bit0 = 0, bit1 = 0;
  logic [15:0] addr0 = 0, addr1 = 0, wdata0 = 0, wdata1 = 0;
  logic        ack0, ack1, port_bit, port_clk, port_read;
  logic [15:0] rdata0, rdata1, port_addr, port_out, port_in;

  always #10 clock50 = ~clock50;

  port_bus_arbiter #(.STROBE_CYC(STROBE_CYC), .HOLD_CYC(HOLD_CYC)) dut (
    .clock50(clock50), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .bit0(bit0), .bit1(bit1), .ack0(ack0), .ack1(ack1),
    .rdata0(rdata0), .rdata1(rdata1),
    .port_addr(port_addr), .port_out(port_out), .port_bit(port_bit),
    .port_clk(port_clk), .port_read(port_read), .port_in(port_in)
  );

  // Bus-side peripheral model: fixed value when forced, else an address hash.
  logic        bus_fix = 1'b0;
  logic [15:0] bus_val = 16'h0000;
  function automatic logic [15:0] bus_f(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h3C5A;
  endfunction
  assign port_in = bus_fix ? bus_val : bus_f(port_addr);

  typedef struct {
    logic        we;
    logic        bv;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [15:0] last_rd[2];
  int          last_served = 1;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic        tr_rd  [2][64];
  logic        tr_clk [2][64];
  logic [15:0] tr_addr[2][64];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clock50);
    cyc++;
  end

  // Monitor: bus protocol tracking and scoreboard pops on every ack.
  initial begin
    logic        prev_stb, stb, active, moved, cap_wr, cap_bit;
    logic [15:0] cap_addr, cap_out;
    int          stb_len, fall_cyc;
    exp_t        e;
    prev_stb = 0; active = 0; moved = 0; stb_len = 0; fall_cyc = 0;
    cap_wr = 0; cap_bit = 0; cap_addr = 0; cap_out = 0;
    forever begin
      @(negedge clock50);
      if (!rst_n) begin
        prev_stb = 0; active = 0; moved = 0; stb_len = 0;
      end else begin
        stb = port_read | port_clk;
        if (stb) chk("strobe_exclusive", {31'd0, port_read & port_clk}, 0);
        if (stb && !prev_stb) begin
          cap_addr = port_addr; cap_out = port_out; cap_bit = port_bit;
          cap_wr = port_clk; stb_len = 0; active = 1; moved = 0;
        end
        if (stb) stb_len++;
        if (!stb && prev_stb) begin
          chk("strobe_len", stb_len, STROBE_CYC);
          fall_cyc = cyc;
        end
        if (active && port_addr !== cap_addr) moved = 1;
        prev_stb = stb;
        for (int r = 0; r < 2; r++) begin
          if ((r == 0) ? ack0 : ack1) begin
            if (((r == 0) ? q0.size() : q1.size()) == 0) begin
              chk("ack_unexpected", {31'd0, (r == 0) ? ack0 : ack1}, 0);
            end else begin
              e = (r == 0) ? q0.pop_front() : q1.pop_front();
              chk("rdata", (r == 0) ? rdata0 : rdata1, e.rdata);
              chk("addr_at_strobe", cap_addr, e.addr);
              chk("addr_at_ack", port_addr, e.addr);
              chk("addr_stable", {31'd0, moved}, 0);
              chk("strobe_kind", {31'd0, cap_wr}, {31'd0, e.we});
              chk("port_out", cap_out, e.wdata);
              chk("port_bit", {31'd0, cap_bit}, {31'd0, e.bv});
              chk("hold_len", cyc - fall_cyc, HOLD_CYC);
            end
            last_served = r;
            active = 0;
          end
        end
      end
    end
  end

  task automatic set_req(input int r, input logic v);
    if (r == 0) req0 = v; else req1 = v;
  endtask

  // Issue one access at posedge+1; returns at posedge+1 of the cycle after ack.
  task automatic do_access(input int r, input logic we, input logic [15:0] a,
                           input logic [15:0] d, input logic bv,
                           input int withdraw, output int ack_at);
    exp_t        e;
    logic [15:0] rv;
    logic        got;
    rv = bus_fix ? bus_val : bus_f(a);
    if (!we) last_rd[r] = rv;
    e = '{we, bv, a, d, last_rd[r]};
    if (r == 0) begin
      q0.push_back(e); we0 = we; addr0 = a; wdata0 = d; bit0 = bv; req0 = 1;
    end else begin
      q1.push_back(e); we1 = we; addr1 = a; wdata1 = d; bit1 = bv; req1 = 1;
    end
    ack_at = -1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clock50);
      if (k < 64) begin
        tr_rd[r][k] = port_read; tr_clk[r][k] = port_clk; tr_addr[r][k] = port_addr;
      end
      got = (r == 0) ? ack0 : ack1;
      if (got) begin
        ack_at = k;
        break;
      end
      @(posedge clock50); #1;
      if (k + 1 == withdraw) set_req(r, 0);
    end
    if (ack_at < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL ack_timeout: requester %0d got no ack within 100 cycles", r);
    end
    @(posedge clock50); #1;
    set_req(r, 0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_port_addr"}, port_addr, 0);
    chk({tag, "_port_out"}, port_out, 0);
    chk({tag, "_port_bit"}, {31'd0, port_bit}, 0);
    chk({tag, "_port_clk"}, {31'd0, port_clk}, 0);
    chk({tag, "_port_read"}, {31'd0, port_read}, 0);
    chk({tag, "_ack0"}, {31'd0, ack0}, 0);
    chk({tag, "_ack1"}, {31'd0, ack1}, 0);
    chk({tag, "_rdata0"}, rdata0, 0);
    chk({tag, "_rdata1"}, rdata1, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, first, t0, t1, t2;
    logic [15:0] b2b_vals[3];
    b2b_vals[0] = 16'h001C; b2b_vals[1] = 16'h0032; b2b_vals[2] = 16'h0021;
    last_rd[0] = 0; last_rd[1] = 0;

    repeat (3) @(posedge clock50);
    #1;
    chk_idle_outputs("reset");
    @(negedge clock50); rst_n = 1;
    @(posedge clock50); #1;

    // Write from requester 1
    do_access(1, 1'b1, KBD_DATA_PORT, 16'hA55A, 1'b1, -1, a1);
    chk("wr_ack_latency", a1, 6);
    for (int k = 0; k <= 6; k++) begin
      chk("wr_port_clk", {31'd0, tr_clk[1][k]}, {31'd0, (k == 2 || k == 3)});
      chk("wr_port_read", {31'd0, tr_rd[1][k]}, 0);
    end
    chk("wr_rdata1_kept", rdata1, 0);

    // Read from requester 0
    bus_fix = 1; bus_val = 16'h0001;
    do_access(0, 1'b0, KBD_STAT_PORT, 16'h0000, 1'b0, -1, a0);
    chk("rd_ack_latency", a0, 6);
    for (int k = 0; k <= 6; k++) begin
      chk("rd_port_read", {31'd0, tr_rd[0][k]}, {31'd0, (k == 2 || k == 3)});
      chk("rd_port_clk", {31'd0, tr_clk[0][k]}, 0);
      if (k >= 1) chk("rd_port_addr", tr_addr[0][k], KBD_STAT_PORT);
    end
    chk("rd_rdata0", rdata0, 16'h0001);
    bus_fix = 0;

    // Two ties in a row
    for (int t = 0; t < 2; t++) begin
`ifdef PORT_ARB_RR_EN
      first = 1 - last_served;
`else
      first = 0;
`endif
      fork
        do_access(0, 1'b0, KBD_STAT_PORT, 16'h1111, 1'b0, -1, a0);
        do_access(1, 1'b1, KBD_DATA_PORT, 16'h2222, 1'b1, -1, a1);
      join
      chk("tie_first_ack", (first == 1) ? a1 : a0, 6);
      chk("tie_second_ack", (first == 1) ? a0 : a1, 13);
    end

    // Early withdraw
    do_access(0, 1'b0, 16'h0123, 16'h0000, 1'b1, 2, a0);
    chk("withdraw_ack_latency", a0, 6);

    // Back-to-back reads with req held through the re-arbitration cycle
    bus_fix = 1;
    bus_val = b2b_vals[0]; t0 = cyc;
    do_access(0, 1'b0, KBD_DATA_PORT, 16'h0000, 1'b0, -1, a0);
    chk("b2b0_latency", a0, 6);
    bus_val = b2b_vals[1]; t1 = cyc;
    do_access(0, 1'b0, KBD_DATA_PORT, 16'h0000, 1'b0, -1, a0);
    chk("b2b1_latency", a0, 6);
    bus_val = b2b_vals[2]; t2 = cyc;
    do_access(0, 1'b0, KBD_DATA_PORT, 16'h0000, 1'b0, -1, a0);
    chk("b2b2_latency", a0, 6);
    chk("b2b_spacing01", t1 - t0, 7);
    chk("b2b_spacing12", t2 - t1, 7);
    chk("b2b_last_rdata0", rdata0, 16'h0021);
    bus_fix = 0;

    // Reset in the middle of a read strobe
    we0 = 0; addr0 = KBD_STAT_PORT; req0 = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock50);
      @(posedge clock50); #1;
    end
    @(negedge clock50);
    chk("rst_mid_strobe_high", {31'd0, port_read}, 1);
    #1 rst_n = 0;
    #1 chk_idle_outputs("rst_mid");
    req0 = 0;
    last_rd[0] = 0; last_rd[1] = 0;
    q0.delete(); q1.delete();
    repeat (2) begin
      @(negedge clock50);
      chk("rst_no_ack0", {31'd0, ack0}, 0);
    end
    rst_n = 1;
    last_served = 1;
    @(posedge clock50); #1;
    do_access(0, 1'b0, KBD_STAT_PORT, 16'h0000, 1'b0, -1, a0);
    chk("post_rst_latency", a0, 6);

    // Random concurrent traffic from both requesters
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          automatic int g = $urandom_range(1, 3);
          automatic int ra;
          do_access(0, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                    1'($urandom_range(0, 1)), -1, ra);
          repeat (g) begin @(posedge clock50); #1; end
        end
      end
      begin
        for (int i = 0; i < 12; i++) begin
          automatic int g = $urandom_range(1, 3);
          automatic int ra;
          do_access(1, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                    1'($urandom_range(0, 1)), -1, ra);
          repeat (g) begin @(posedge clock50); #1; end
        end
      end
    join

    repeat (4) @(posedge clock50);
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
